// File: rtl/i2c_config_sequencer.sv
// Power-up / hot-plug register loader: walks a ROM of {reg, data} pairs and feeds
// one 24-bit write at a time to a single-transaction I2C write master.
module i2c_config_sequencer #(
   parameter int         NUM_REGS       = 32,
   parameter logic [7:0] SLAVE_ADDR     = 8'h72,
   parameter int         POWERUP_CYCLES = 1000000,
   parameter int         GAP_CYCLES     = 16,
   parameter int         MAX_RETRIES    = 3,
   localparam int        IDX_W          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             hpd,
   output logic [IDX_W-1:0] rom_index,
   input  logic [15:0]      rom_data,
   output logic [23:0]      i2c_data,
   output logic             i2c_go,
   input  logic             i2c_done,
   input  logic             i2c_ack_err,
   output logic             busy,
   output logic             config_done,
   output logic             config_err,
   output logic [2:0]       fsm_state
);

   // Handshake: i2c_go is a level request held from the cycle after ISSUE until the
   // cycle after i2c_done is seen high; i2c_data is frozen for that whole window.

   localparam int CNT_MAX = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [CNT_W-1:0]   PWR_LAST   = CNT_W'((POWERUP_CYCLES > 0) ? POWERUP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      PWR_WAIT  = 3'd0,
      LOAD      = 3'd1,
      ISSUE     = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4,
      DONE      = 3'd5,
      ERROR     = 3'd6
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic [RETRY_W-1:0] retry;
   logic               table_end;
   logic               restart_pend;
   logic               hpd_meta;
   logic               hpd_sync;
   logic               hpd_prev;

   logic pwr_end;
   logic gap_end;
   logic ack_seen;
   logic restart_req;
   logic restart_take;

   assign pwr_end      = (cnt >= PWR_LAST);
   assign gap_end      = (cnt >= GAP_LAST) && !i2c_done;
   assign ack_seen     = (state == WAIT_DONE) && i2c_done;
   assign restart_req  = start | (hpd_sync & ~hpd_prev);
   assign restart_take = restart_pend &&
                         (((state == GAP) && gap_end) || (state == DONE) || (state == ERROR));

   assign rom_index = idx;
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= PWR_WAIT;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         PWR_WAIT:  if (pwr_end) state_next = LOAD;
         LOAD:      state_next = (rom_data == 16'hFFFF) ? DONE : ISSUE;
         ISSUE:     state_next = WAIT_DONE;
         WAIT_DONE: if (i2c_done)
                       state_next = (i2c_ack_err && (retry == RETRY_LAST)) ? ERROR : GAP;
         GAP:       if (gap_end)
                       state_next = (restart_pend || !table_end) ? LOAD : DONE;
         DONE,
         ERROR:     if (restart_pend) state_next = LOAD;
         default:   state_next = PWR_WAIT;
      endcase
   end

   always_comb begin
      i2c_go      = (state == WAIT_DONE);
      busy        = (state != DONE) && (state != ERROR);
      config_done = (state == DONE);
      config_err  = (state == ERROR);
   end

   // One counter serves both the power-up wait and the inter-transaction gap.
   always_ff @(posedge clk) begin
      if (!reset_n || (state_next != state)) begin
         cnt <= '0;
      end else if (((state == PWR_WAIT) && !pwr_end) || ((state == GAP) && (cnt < GAP_LAST))) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hpd_meta <= 1'b0;
         hpd_sync <= 1'b0;
         hpd_prev <= 1'b0;
      end else begin
         hpd_meta <= hpd;
         hpd_sync <= hpd_meta;
         hpd_prev <= hpd_sync;
      end
   end

   // Requests during power-up are dropped; a request coinciding with a take is merged.
   always_ff @(posedge clk) begin
      if (!reset_n || (state == PWR_WAIT)) restart_pend <= 1'b0;
      else if (restart_take)               restart_pend <= 1'b0;
      else if (restart_req)                restart_pend <= 1'b1;
   end

   // idx saturates at the last entry; table_end stands in for idx == NUM_REGS.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx       <= '0;
         retry     <= '0;
         table_end <= 1'b0;
         i2c_data  <= '0;
      end else begin
         if (restart_take || ((state == PWR_WAIT) && pwr_end)) begin
            idx       <= '0;
            retry     <= '0;
            table_end <= 1'b0;
         end else if (ack_seen) begin
            if (!i2c_ack_err) begin
               retry <= '0;
               if (idx == IDX_LAST) table_end <= 1'b1;
               else                 idx       <= idx + 1'b1;
            end else if (retry != RETRY_LAST) begin
               retry <= retry + 1'b1;
            end
         end
         if (state == LOAD) i2c_data <= {SLAVE_ADDR, rom_data};
      end
   end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer: scenario table plus hand-written
// restart / reset sequences, against a small I2C master model.
module tb_i2c_config_sequencer;

   localparam int NUM_REGS  = 8;
   localparam int POWERUP   = 10;
   localparam int GAP       = 4;
   localparam int RETRIES   = 3;
   localparam int ACK_DELAY = 20;
   localparam int IDX_W     = 3;
   localparam int FIRST_GO  = POWERUP + 2;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic             start_drv;
   logic             start_auto;
   logic             hpd;
   logic [IDX_W-1:0] rom_index;
   logic [15:0]      rom_data;
   logic [23:0]      i2c_data;
   logic             i2c_go;
   logic             i2c_done;
   logic             i2c_ack_err;
   logic             busy;
   logic             config_done;
   logic             config_err;
   logic [2:0]       fsm_state;

   logic [15:0] rom_mem [NUM_REGS];
   assign rom_data = rom_mem[rom_index];
   assign start    = start_drv | start_auto;

   i2c_config_sequencer #(
      .NUM_REGS      (NUM_REGS),
      .SLAVE_ADDR    (8'h72),
      .POWERUP_CYCLES(POWERUP),
      .GAP_CYCLES    (GAP),
      .MAX_RETRIES   (RETRIES)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .hpd        (hpd),
      .rom_index  (rom_index),
      .rom_data   (rom_data),
      .i2c_data   (i2c_data),
      .i2c_go     (i2c_go),
      .i2c_done   (i2c_done),
      .i2c_ack_err(i2c_ack_err),
      .busy       (busy),
      .config_done(config_done),
      .config_err (config_err),
      .fsm_state  (fsm_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   logic [23:0] txn_q [$];
   logic [23:0] exp_q [$];
   int base        = 0;
   int viol        = 0;
   int viol_base   = 0;
   int max_idx     = 0;
   int nack_first  = 0;
   bit nack_all    = 1'b0;
   int start_on_txn = 0;

   int          m_cnt;
   bit          m_active;
   bit          prev_go;
   bit          had_fall;
   int          low_cnt;
   int          ordinal;
   logic [23:0] prev_data;

   // Master model and protocol monitor share one negedge process.
   always @(negedge clk) begin
      start_auto = 1'b0;
      if (!reset_n) begin
         m_active    = 1'b0;
         m_cnt       = 0;
         i2c_done    = 1'b0;
         i2c_ack_err = 1'b0;
         max_idx     = 0;
         had_fall    = 1'b0;
         low_cnt     = 0;
      end else begin
         if (int'(rom_index) > max_idx) max_idx = int'(rom_index);
         if (config_done && config_err) begin
            viol++;
            $display("note: config_done and config_err both high at %0t", $time);
         end
         if (prev_go && i2c_go && (i2c_data != prev_data)) begin
            viol++;
            $display("note: i2c_data changed while go high at %0t", $time);
         end
         if (prev_go && !i2c_go && !i2c_done) begin
            viol++;
            $display("note: i2c_go dropped before done at %0t", $time);
         end
         if (!prev_go && i2c_go && had_fall && (low_cnt < GAP + 2)) begin
            viol++;
            $display("note: gap of %0d cycles at %0t", low_cnt, $time);
         end
         if (prev_go && !i2c_go) begin
            had_fall = 1'b1;
            low_cnt  = 1;
         end else if (!i2c_go) begin
            low_cnt++;
         end

         if (i2c_done) begin
            i2c_done    = 1'b0;
            i2c_ack_err = 1'b0;
         end else if (m_active) begin
            m_cnt++;
            if (m_cnt >= ACK_DELAY) begin
               m_active    = 1'b0;
               ordinal     = txn_q.size() - base;
               i2c_done    = 1'b1;
               i2c_ack_err = nack_all || (ordinal <= nack_first);
               if ((start_on_txn != 0) && (ordinal == start_on_txn)) start_auto = 1'b1;
            end
         end else if (i2c_go) begin
            m_active = 1'b1;
            m_cnt    = 0;
            txn_q.push_back(i2c_data);
         end
      end
      prev_go   = reset_n && i2c_go;
      prev_data = i2c_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_log(input string tag);
      int n;
      n = txn_q.size() - base;
      check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < txn_q.size()) check({tag, "_word"}, 32'(txn_q[base + i]), 32'(exp_q[i]));
      end
      exp_q.delete();
   endtask

   task automatic wait_go(input int budget, output int n);
      n = 0;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (i2c_go) return;
      end
      n = -1;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, 32'(busy), 32'(0));
   endtask

   task automatic wait_txns(input int count, input int budget);
      int n;
      n = 0;
      while (((txn_q.size() - base) < count) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      check("txn_wait", 32'(txn_q.size() - base >= count), 32'(1));
   endtask

   task automatic run_reset();
      reset_n   = 1'b0;
      start_drv = 1'b0;
      repeat (2) @(negedge clk);
      base      = txn_q.size();
      viol_base = viol;
      reset_n   = 1'b1;
   endtask

   task automatic load_rom3();
      for (int i = 0; i < NUM_REGS; i++) rom_mem[i] = 16'hFFFF;
      rom_mem[0] = 16'h1234;
      rom_mem[1] = 16'h5678;
      rom_mem[2] = 16'h9ABC;
   endtask

   task automatic push_pass3();
      exp_q.push_back(24'h721234);
      exp_q.push_back(24'h725678);
      exp_q.push_back(24'h729ABC);
   endtask

   typedef struct {
      logic [NUM_REGS-1:0][15:0] rom;
      int                        nack_first;
      bit                        nack_all;
      int                        n_words;
      logic [11:0][23:0]         words;
      bit                        exp_done;
      bit                        exp_err;
      int                        max_idx;
      int                        final_idx;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int n;
      reset_n      = 1'b0;
      start_drv    = 1'b0;
      hpd          = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rom_mem[i] = 16'hFFFF;

      // 0: three entries then end marker
      vecs[0].rom = {NUM_REGS{16'hFFFF}};
      vecs[0].rom[0] = 16'h1234; vecs[0].rom[1] = 16'h5678; vecs[0].rom[2] = 16'h9ABC;
      vecs[0].nack_first = 0; vecs[0].nack_all = 1'b0; vecs[0].n_words = 3;
      vecs[0].words = '0;
      vecs[0].words[0] = 24'h721234; vecs[0].words[1] = 24'h725678; vecs[0].words[2] = 24'h729ABC;
      vecs[0].exp_done = 1'b1; vecs[0].exp_err = 1'b0; vecs[0].max_idx = 3; vecs[0].final_idx = 3;
      // 1: end marker at entry 1
      vecs[1].rom = {NUM_REGS{16'hFFFF}};
      vecs[1].rom[0] = 16'h1234;
      vecs[1].nack_first = 0; vecs[1].nack_all = 1'b0; vecs[1].n_words = 1;
      vecs[1].words = '0;
      vecs[1].words[0] = 24'h721234;
      vecs[1].exp_done = 1'b1; vecs[1].exp_err = 1'b0; vecs[1].max_idx = 1; vecs[1].final_idx = 1;
      // 2: two NACKs on entry 0, then ACKs
      vecs[2].rom = vecs[0].rom;
      vecs[2].nack_first = 2; vecs[2].nack_all = 1'b0; vecs[2].n_words = 5;
      vecs[2].words = '0;
      vecs[2].words[0] = 24'h721234; vecs[2].words[1] = 24'h721234; vecs[2].words[2] = 24'h721234;
      vecs[2].words[3] = 24'h725678; vecs[2].words[4] = 24'h729ABC;
      vecs[2].exp_done = 1'b1; vecs[2].exp_err = 1'b0; vecs[2].max_idx = 3; vecs[2].final_idx = 3;
      // 3: full table without end marker, idx saturates at NUM_REGS-1
      for (int i = 0; i < NUM_REGS; i++) vecs[3].rom[i] = 16'h0100 + 16'(i);
      vecs[3].nack_first = 0; vecs[3].nack_all = 1'b0; vecs[3].n_words = 8;
      vecs[3].words = '0;
      for (int i = 0; i < NUM_REGS; i++) vecs[3].words[i] = 24'h720100 + 24'(i);
      vecs[3].exp_done = 1'b1; vecs[3].exp_err = 1'b0; vecs[3].max_idx = 7; vecs[3].final_idx = 7;
      // 4: always NACK, 4 attempts then ERROR
      vecs[4].rom = vecs[0].rom;
      vecs[4].nack_first = 0; vecs[4].nack_all = 1'b1; vecs[4].n_words = 4;
      vecs[4].words = '0;
      for (int i = 0; i < 4; i++) vecs[4].words[i] = 24'h721234;
      vecs[4].exp_done = 1'b0; vecs[4].exp_err = 1'b1; vecs[4].max_idx = 0; vecs[4].final_idx = 0;

      repeat (3) @(negedge clk);
      check("rst_go",    32'(i2c_go),      32'(0));
      check("rst_data",  32'(i2c_data),    32'(0));
      check("rst_index", 32'(rom_index),   32'(0));
      check("rst_busy",  32'(busy),        32'(1));
      check("rst_done",  32'(config_done), 32'(0));
      check("rst_err",   32'(config_err),  32'(0));
      check("rst_state", 32'(fsm_state),   32'(0));

      for (int s = 0; s < 5; s++) begin
         for (int i = 0; i < NUM_REGS; i++) rom_mem[i] = vecs[s].rom[i];
         nack_first = vecs[s].nack_first;
         nack_all   = vecs[s].nack_all;
         run_reset();
         wait_go(200, n);
         check("first_go_latency", 32'(n), 32'(FIRST_GO));
         wait_idle("vec", 2000);
         for (int i = 0; i < vecs[s].n_words; i++) exp_q.push_back(vecs[s].words[i]);
         check_log("vec");
         check("vec_done",    32'(config_done), 32'(vecs[s].exp_done));
         check("vec_err",     32'(config_err),  32'(vecs[s].exp_err));
         check("vec_go_low",  32'(i2c_go),      32'(0));
         check("vec_max_idx", 32'(max_idx),     32'(vecs[s].max_idx));
         check("vec_index",   32'(rom_index),   32'(vecs[s].final_idx));
         check("vec_protocol", 32'(viol - viol_base), 32'(0));
      end

      // Start pulse out of ERROR clears the flag and reruns from entry 0
      nack_all   = 1'b0;
      nack_first = 0;
      base       = txn_q.size();
      start_drv  = 1'b1;
      @(negedge clk);
      start_drv  = 1'b0;
      @(negedge clk);
      check("restart_err_clear", 32'(config_err), 32'(0));
      check("restart_busy",      32'(busy),       32'(1));
      wait_idle("restart", 2000);
      push_pass3();
      check_log("restart");
      check("restart_done", 32'(config_done), 32'(1));

      // hpd rises while entry 1 is in flight
      load_rom3();
      run_reset();
      wait_txns(2, 500);
      hpd = 1'b1;
      wait_idle("hpd", 3000);
      exp_q.push_back(24'h721234);
      exp_q.push_back(24'h725678);
      push_pass3();
      check_log("hpd");
      check("hpd_done",     32'(config_done), 32'(1));
      check("hpd_protocol", 32'(viol - viol_base), 32'(0));

      // hpd edge and start land in the same cycle: one rerun only
      hpd = 1'b0;
      repeat (4) @(negedge clk);
      base = txn_q.size();
      hpd  = 1'b1;
      repeat (2) @(negedge clk);
      start_drv = 1'b1;
      @(negedge clk);
      start_drv = 1'b0;
      @(negedge clk);
      check("simul_busy", 32'(busy), 32'(1));
      wait_idle("simul", 2000);
      push_pass3();
      check_log("simul");
      check("simul_done", 32'(config_done), 32'(1));

      // start coincides with i2c_done of the last entry: one more full pass
      hpd          = 1'b0;
      start_on_txn = 3;
      run_reset();
      wait_idle("late", 3000);
      start_on_txn = 0;
      push_pass3();
      push_pass3();
      check_log("late");
      check("late_done", 32'(config_done), 32'(1));

      // start during power-up is dropped; reset mid-transaction restarts the wait
      run_reset();
      repeat (3) @(negedge clk);
      start_drv = 1'b1;
      @(negedge clk);
      start_drv = 1'b0;
      wait_go(200, n);
      check("pwr_start_latency", 32'(n + 4), 32'(FIRST_GO));
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst_go",    32'(i2c_go),      32'(0));
      check("midrst_done",  32'(config_done), 32'(0));
      check("midrst_state", 32'(fsm_state),   32'(0));
      check("midrst_busy",  32'(busy),        32'(1));
      base      = txn_q.size();
      viol_base = viol;
      reset_n   = 1'b1;
      wait_go(200, n);
      check("midrst_latency", 32'(n), 32'(FIRST_GO));
      wait_idle("midrst", 2000);
      push_pass3();
      check_log("midrst");
      check("midrst_cfg_done", 32'(config_done), 32'(1));
      check("midrst_protocol", 32'(viol - viol_base), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2c_config_sequencer.md
# i2c_config_sequencer

Walks a table of register writes and drives the single-transaction I2C write master one 24-bit word at a time. Sits directly upstream of the I2C master: it supplies the {slave address, register address, data} word and the go strobe, then waits for completion. It runs once after power-up and again on HDMI hot-plug or an explicit start, and reports overall done/error status to the top level.

## Interface
- NUM_REGS, 32: number of table entries; index width IDX_W = clog2(NUM_REGS), minimum 1
- SLAVE_ADDR, 8'h72: 8-bit write address placed in i2c_data[23:16]
- POWERUP_CYCLES, 1000000: clk cycles to wait after reset before the first write (200 ms at 5 MHz)
- GAP_CYCLES, 16: minimum idle clk cycles between transactions
- MAX_RETRIES, 3: re-attempts per entry after a NACK before the sequence aborts

- clk  in  1  reference clock; same clock as the I2C master refClock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle request to rerun the whole table
- hpd  in  1  asynchronous hot-plug detect from the connector
- rom_index  out  IDX_W  table address to the external combinational ROM
- rom_data  in  16  {reg_addr[15:8], reg_data[7:0]}, valid in the same cycle as rom_index; 16'hFFFF marks end of table
- i2c_data  out  24  {SLAVE_ADDR, rom_data} word for the master
- i2c_go  out  1  transaction request, level
- i2c_done  in  1  master completion, level, high for at least 1 clk
- i2c_ack_err  in  1  NACK flag, valid while i2c_done is high
- busy  out  1  high in every state except DONE and ERROR
- config_done  out  1  table completed without abort
- config_err  out  1  an entry failed MAX_RETRIES+1 attempts

## Operation
- hpd passes through a 2-flop synchronizer. A rising edge or start sets restart_pend.
- States and transitions:
  - PWR_WAIT: counts POWERUP_CYCLES, then goes to LOAD with idx=0 and retry=0.
  - LOAD: registers i2c_data <= {SLAVE_ADDR, rom_data}.
    - If rom_data == 16'hFFFF, goes to DONE.
    - Otherwise goes to ISSUE.
  - ISSUE: sets i2c_go=1, then goes to WAIT_DONE.
  - WAIT_DONE: holds i2c_go=1 until i2c_done=1. In that cycle, clears i2c_go and samples i2c_ack_err.
    - On ACK: idx++, retry=0.
    - On NACK with retry < MAX_RETRIES: retry++, idx unchanged.
    - On NACK with retry == MAX_RETRIES: goes to ERROR.
    - Otherwise goes to GAP.
  - GAP: waits GAP_CYCLES and until i2c_done=0.
    - If restart_pend: clears it, sets idx=0, retry=0, goes to LOAD.
    - Else if idx == NUM_REGS: goes to DONE.
    - Else goes to LOAD.
  - DONE / ERROR: terminal. restart_pend clears config_done and config_err, sets idx=0, retry=0, and goes to LOAD.
- A restart during PWR_WAIT is discarded, because the sequence is about to run anyway.
- A restart during an active transaction never aborts the master. It takes effect in GAP.
- rom_index = idx at all times. idx saturates and never wraps.

## Timing
- Reset values: i2c_go=0, i2c_data=0, rom_index=0, busy=1, config_done=0, config_err=0, restart_pend=0, state=PWR_WAIT.
- First i2c_go rise: reset release + POWERUP_CYCLES + 2 clk (LOAD, ISSUE).
- i2c_data is stable from LOAD until the cycle after i2c_done; it never changes while i2c_go=1.
- i2c_go falls 1 clk after i2c_done is sampled high. This guarantees it is low before the master re-samples go from idle.
- Inter-transaction gap: at least GAP_CYCLES + 2 clk from i2c_go falling to the next i2c_go rise.
- config_done / config_err assert on entry to DONE / ERROR and hold until restart. They are mutually exclusive.
- hpd-to-action latency: 2 sync cycles + 1 edge-detect cycle.
- Simultaneous start and hpd edge: a single restart.
- A restart request in the same cycle as the i2c_done of the last entry is honoured: one further full pass runs.

## Test plan
- Reset, POWERUP_CYCLES=10, 3-entry ROM {1234, 5678, 9ABC}, master model ACKs after 20 clk:
  - i2c_data = 72_1234, 72_5678, 72_9ABC in order
  - config_done=1 after the third entry, busy=0
- ROM entry 1 = FFFF:
  - exactly one transaction, then DONE
  - no access at index 2
- Model NACKs entry 0 twice, then ACKs:
  - three transactions with identical i2c_data
  - sequence continues, config_err=0
- Model always NACKs, MAX_RETRIES=3:
  - exactly 4 attempts, then config_err=1, busy=0, i2c_go=0
  - a start pulse clears config_err and reruns from index 0
- hpd rises during WAIT_DONE of entry 1:
  - entry 1 completes, i2c_go never drops early
  - next i2c_data is entry 0
- reset_n low mid-transaction:
  - next clk gives i2c_go=0, config_done=0, state PWR_WAIT
  - full POWERUP_CYCLES delay before the first go
